// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter_if
//  Description : Bundle of the fetch, data and shared-memory handshake
//                signals around the SRAM request arbiter.
//                slave  = arbiter view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_req_arbiter_if;
    // instruction-fetch side
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_cancel;
    // data side
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    // shared memory side
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr, inst_cancel,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_req_arbiter
//  Description : Shares one req/addr_ok/data_ok memory port between the
//                instruction-fetch and data requesters, one outstanding
//                transaction at a time, with in-flight fetch cancellation.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
    parameter logic DATA_PRIO = 1'b1   // 1: data always wins, 0: round-robin
) (
    input  logic              clk,
    input  logic              resetn,
    sram_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic c_OWNER_INST = 1'b0;
    localparam logic c_OWNER_DATA = 1'b1;

    state_t r_state;
    state_t w_state_next;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_cancel_pend;

    logic   w_any_req;
    logic   w_grant;
    logic   w_owner_req;
    logic   w_mem_req;
    logic   w_handshake;
    logic   w_resp_done;
    logic   w_inst_drop;

    assign w_any_req   = bus.inst_req | bus.data_req;
    assign w_owner_req = (r_owner == c_OWNER_DATA) ? bus.data_req : bus.inst_req;
    // mem_req depends only on state, owner and the owner's req, never on mem_data_ok
    assign w_mem_req   = (r_state == S_ADDR) & w_owner_req;
    assign w_handshake = w_mem_req & bus.mem_addr_ok;
    assign w_resp_done = (r_state == S_RESP) & bus.mem_data_ok;
    assign w_inst_drop = r_cancel_pend | bus.inst_cancel;

    // Pick the next owner: fixed data priority, or the master not granted last on a tie
    always_comb begin
        w_grant = bus.data_req;
        if (!DATA_PRIO && bus.data_req && bus.inst_req) begin
            w_grant = ~r_last_grant;
        end
    end

    // State, owner, fairness and cancel bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_owner       <= c_OWNER_INST;
            r_last_grant  <= c_OWNER_INST;
            r_cancel_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            // the response that ends the transaction always clears the pending cancel,
            // so a cancel seen in that same cycle cannot leak into the next fetch
            if (w_resp_done) begin
                r_cancel_pend <= 1'b0;
            end else if (bus.inst_cancel && r_owner == c_OWNER_INST &&
                         (r_state == S_RESP || w_handshake)) begin
                r_cancel_pend <= 1'b1;
            end
        end
    end

    // Next-state decode and all port outputs
    always_comb begin
        w_state_next     = r_state;
        bus.mem_req      = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_size     = 2'd0;
        bus.mem_wstrb    = 4'd0;
        bus.mem_addr     = 32'd0;
        bus.mem_wdata    = 32'd0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'd0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.mem_req = w_mem_req;
                if (r_owner == c_OWNER_DATA) begin
                    bus.mem_wr       = bus.data_wr;
                    bus.mem_size     = bus.data_size;
                    bus.mem_wstrb    = bus.data_wstrb;
                    bus.mem_addr     = bus.data_addr;
                    bus.mem_wdata    = bus.data_wdata;
                    bus.data_addr_ok = w_handshake;
                end else begin
                    // fetches are always plain word reads
                    bus.mem_size     = 2'd2;
                    bus.mem_addr     = bus.inst_addr;
                    bus.inst_addr_ok = w_handshake;
                end
                if (w_handshake) begin
                    w_state_next = S_RESP;
                end else if (!w_owner_req) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RESP: begin
                if (w_resp_done) begin
                    w_state_next = S_IDLE;
                    if (r_owner == c_OWNER_DATA) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = bus.mem_rdata;
                    end else if (!w_inst_drop) begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = bus.mem_rdata;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_req_arbiter
//  Description : Drives a fixed-priority and a round-robin arbiter with the
//                same stimulus and checks both against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    typedef struct packed {
        logic        inst_addr_ok;
        logic        inst_data_ok;
        logic [31:0] inst_rdata;
        logic        data_addr_ok;
        logic        data_data_ok;
        logic [31:0] data_rdata;
        logic        mem_req;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cancel;
    logic [31:0] inst_addr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    outs_t obs [2];

    always #5 clk = ~clk;

    // instance 0: fixed data priority, instance 1: round-robin
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_req_arbiter_if ifc ();
        assign ifc.inst_req    = inst_req;
        assign ifc.inst_addr   = inst_addr;
        assign ifc.inst_cancel = inst_cancel;
        assign ifc.data_req    = data_req;
        assign ifc.data_wr     = data_wr;
        assign ifc.data_size   = data_size;
        assign ifc.data_wstrb  = data_wstrb;
        assign ifc.data_addr   = data_addr;
        assign ifc.data_wdata  = data_wdata;
        assign ifc.mem_addr_ok = mem_addr_ok;
        assign ifc.mem_data_ok = mem_data_ok;
        assign ifc.mem_rdata   = mem_rdata;
        assign obs[g] = {ifc.inst_addr_ok, ifc.inst_data_ok, ifc.inst_rdata,
                         ifc.data_addr_ok, ifc.data_data_ok, ifc.data_rdata,
                         ifc.mem_req, ifc.mem_wr, ifc.mem_size, ifc.mem_wstrb,
                         ifc.mem_addr, ifc.mem_wdata};
        sram_req_arbiter #(.DATA_PRIO((g == 0) ? 1'b1 : 1'b0)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (ifc.slave)
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model: one transaction record per arbiter ----
    logic m_busy [2];   // a transaction currently holds the port
    logic m_who  [2];   // 0 = fetch, 1 = data
    logic m_sent [2];   // address already accepted by memory
    logic m_drop [2];   // fetch response must be discarded
    logic m_prev [2];   // master that won the previous grant

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_who[k] = 1'b0; m_sent[k] = 1'b0;
            m_drop[k] = 1'b0; m_prev[k] = 1'b0;
        end
    endtask

    function automatic outs_t model_out(int k);
        outs_t o;
        logic  req;
        o = '0;
        if (!resetn || !m_busy[k]) return o;
        if (!m_sent[k]) begin
            req = m_who[k] ? data_req : inst_req;
            o.mem_req = req;
            if (m_who[k]) begin
                o.mem_wr = data_wr;  o.mem_size = data_size; o.mem_wstrb = data_wstrb;
                o.mem_addr = data_addr; o.mem_wdata = data_wdata;
                o.data_addr_ok = req & mem_addr_ok;
            end else begin
                o.mem_size = 2'd2; o.mem_addr = inst_addr;
                o.inst_addr_ok = req & mem_addr_ok;
            end
        end else if (mem_data_ok) begin
            if (m_who[k]) begin
                o.data_data_ok = 1'b1; o.data_rdata = mem_rdata;
            end else if (!(m_drop[k] || inst_cancel)) begin
                o.inst_data_ok = 1'b1; o.inst_rdata = mem_rdata;
            end
        end
        return o;
    endfunction

    task automatic model_tick(int k);
        logic winner;
        if (!m_busy[k]) begin
            if (inst_req || data_req) begin
                if (k == 0 || !(inst_req && data_req)) winner = data_req;
                else winner = ~m_prev[k];
                m_busy[k] = 1'b1; m_who[k] = winner; m_sent[k] = 1'b0;
                m_drop[k] = 1'b0; m_prev[k] = winner;
            end
        end else if (!m_sent[k]) begin
            if (!(m_who[k] ? data_req : inst_req)) m_busy[k] = 1'b0;
            else if (mem_addr_ok) begin
                m_sent[k] = 1'b1;
                m_drop[k] = !m_who[k] && inst_cancel;
            end
        end else if (mem_data_ok) begin
            m_busy[k] = 1'b0; m_drop[k] = 1'b0;
        end else if (!m_who[k] && inst_cancel) begin
            m_drop[k] = 1'b1;
        end
    endtask

    task automatic compare_all();
        outs_t e;
        string p;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            p = (k == 0) ? "prio" : "rr";
            check({p, ".inst_addr_ok"}, 32'(obs[k].inst_addr_ok), 32'(e.inst_addr_ok));
            check({p, ".inst_data_ok"}, 32'(obs[k].inst_data_ok), 32'(e.inst_data_ok));
            check({p, ".inst_rdata"},   obs[k].inst_rdata,         e.inst_rdata);
            check({p, ".data_addr_ok"}, 32'(obs[k].data_addr_ok), 32'(e.data_addr_ok));
            check({p, ".data_data_ok"}, 32'(obs[k].data_data_ok), 32'(e.data_data_ok));
            check({p, ".data_rdata"},   obs[k].data_rdata,         e.data_rdata);
            check({p, ".mem_req"},      32'(obs[k].mem_req),      32'(e.mem_req));
            check({p, ".mem_wr"},       32'(obs[k].mem_wr),       32'(e.mem_wr));
            check({p, ".mem_size"},     32'(obs[k].mem_size),     32'(e.mem_size));
            check({p, ".mem_wstrb"},    32'(obs[k].mem_wstrb),    32'(e.mem_wstrb));
            check({p, ".mem_addr"},     obs[k].mem_addr,           e.mem_addr);
            check({p, ".mem_wdata"},    obs[k].mem_wdata,          e.mem_wdata);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic settle();
        #1;
        if (!resetn) model_reset();
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (resetn) begin
            model_tick(0);
            model_tick(1);
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; inst_addr = 32'd0; inst_cancel = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        step(); step();
        resetn = 1'b1;
        step();

        // ---- fetch alone ----
        inst_req = 1'b1; inst_addr = 32'h1C00_0000;
        settle(); check("fetch.idle_mem_req", 32'(obs[0].mem_req), 32'd0); advance();
        mem_addr_ok = 1'b1;
        settle();
        check("fetch.mem_req",      32'(obs[0].mem_req),      32'd1);
        check("fetch.inst_addr_ok", 32'(obs[0].inst_addr_ok), 32'd1);
        check("fetch.mem_addr",     obs[0].mem_addr,          32'h1C00_0000);
        advance();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
        settle();
        check("fetch.inst_data_ok", 32'(obs[0].inst_data_ok), 32'd1);
        check("fetch.inst_rdata",   obs[0].inst_rdata,        32'h0280_0C0C);
        check("fetch.data_data_ok", 32'(obs[0].data_data_ok), 32'd0);
        advance();
        clear_inputs(); step();

        // ---- contention: data write goes first ----
        inst_req = 1'b1; inst_addr = 32'h1C00_0020;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h1C00_8000; data_wdata = 32'hDEAD_BEEF;
        step();
        mem_addr_ok = 1'b1;
        settle();
        check("cont.mem_wr",        32'(obs[0].mem_wr),       32'd1);
        check("cont.mem_wdata",     obs[0].mem_wdata,         32'hDEAD_BEEF);
        check("cont.inst_addr_ok",  32'(obs[0].inst_addr_ok), 32'd0);
        check("cont.data_addr_ok",  32'(obs[0].data_addr_ok), 32'd1);
        advance();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        settle(); check("cont.data_data_ok", 32'(obs[0].data_data_ok), 32'd1); advance();
        mem_data_ok = 1'b0;
        settle(); check("cont.bubble_mem_req", 32'(obs[0].mem_req), 32'd0); advance();
        mem_addr_ok = 1'b1;
        settle();
        check("cont.fetch_addr",    obs[0].mem_addr,          32'h1C00_0020);
        check("cont.fetch_addr_ok", 32'(obs[0].inst_addr_ok), 32'd1);
        advance();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        step();
        clear_inputs(); step();

        // ---- memory stall on a data read ----
        data_req = 1'b1; data_size = 2'd0; data_addr = 32'h1C00_0101;
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall.mem_req",      32'(obs[0].mem_req),      32'd1);
            check("stall.mem_addr",     obs[0].mem_addr,          32'h1C00_0101);
            check("stall.data_addr_ok", 32'(obs[0].data_addr_ok), 32'd0);
            advance();
        end
        mem_addr_ok = 1'b1;
        settle(); check("stall.handshake", 32'(obs[0].data_addr_ok), 32'd1); advance();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        step();
        clear_inputs(); step();

        // ---- cancel of an in-flight fetch ----
        inst_req = 1'b1; inst_addr = 32'h1C00_0010;
        step();
        mem_addr_ok = 1'b1; step();
        inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1; step();
        inst_cancel = 1'b0; step(); step();
        mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        settle(); check("cancel.inst_data_ok", 32'(obs[0].inst_data_ok), 32'd0); advance();
        clear_inputs(); step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0014; step();
        mem_addr_ok = 1'b1; step();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0011_2233;
        settle(); check("cancel.next_fetch_ok", 32'(obs[0].inst_data_ok), 32'd1); advance();
        clear_inputs(); step();

        // ---- reset while waiting for the response ----
        data_req = 1'b1; data_addr = 32'h1C00_0200; step();
        mem_addr_ok = 1'b1; step();
        data_req = 1'b0; mem_addr_ok = 1'b0; step();
        resetn = 1'b0; inst_req = 1'b1;
        settle(); check("rst.mem_req", 32'(obs[0].mem_req), 32'd0); advance();
        resetn = 1'b1; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
        settle();
        check("rst.late_data_ok", 32'(obs[0].data_data_ok), 32'd0);
        check("rst.late_inst_ok", 32'(obs[0].inst_data_ok), 32'd0);
        advance();
        clear_inputs(); step();

        // ---- randomized traffic ----
        for (int n = 0; n < 4000; n++) begin
            if (!inst_req || $urandom_range(0, 99) < 15) begin
                inst_req  = ($urandom_range(0, 99) < 50);
                inst_addr = $urandom;
            end
            if (!data_req || $urandom_range(0, 99) < 15) begin
                data_req   = ($urandom_range(0, 99) < 50);
                data_wr    = ($urandom_range(0, 1) == 1);
                data_size  = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            inst_cancel = ($urandom_range(0, 99) < 10);
            mem_addr_ok = ($urandom_range(0, 1) == 1);
            mem_data_ok = ($urandom_range(0, 99) < 40);
            mem_rdata   = $urandom;
            resetn      = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Two-master arbiter sharing one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage).
- Uses the req/addr_ok/data_ok split-transaction protocol on every side, with at most one outstanding transaction.
- Routes responses back to the issuing master.
- Supports cancellation of an in-flight fetch on exception/ertn redirect, so the IF stage can redirect without receiving stale data.

Parameters:
- DATA_PRIO, 1, 1 = data master has fixed priority; 0 = round-robin (the master not granted last wins a tie).

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  32  fetch address (fetches are 32-bit reads).
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data returned.
- inst_rdata  out  32  fetch data.
- inst_cancel  in  1  discard the response of the in-flight fetch.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = write.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte strobes.
- data_addr  in  32  data address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  data response (read data or write ack).
- data_rdata  out  32  read data.
- mem_req  out  1  shared port request.
- mem_wr  out  1  shared port write.
- mem_size  out  2  shared port size.
- mem_wstrb  out  4  shared port strobes.
- mem_addr  out  32  shared port address.
- mem_wdata  out  32  shared port write data.
- mem_addr_ok  in  1  memory address accepted.
- mem_data_ok  in  1  memory response.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, ADDR, RESP. Registers: owner (0 = inst, 1 = data), last_grant, cancel_pend.
- Reset (async, resetn=0): state=IDLE, owner=0, last_grant=0, cancel_pend=0. All outputs 0 immediately and while reset is held, including mem_req. Any outstanding transaction is abandoned; no response is forwarded after reset release.
- IDLE:
  - If data_req or inst_req, latch owner per the DATA_PRIO rule, last_grant<=owner, go to ADDR.
  - Otherwise stay. No outputs are asserted in IDLE.
- ADDR:
  - mem_req = owner's req. mem_wr/size/wstrb/addr/wdata driven combinationally from the owner.
  - Inst owner forces wr=0, size=2, wstrb=0, wdata=0.
  - The non-owner's addr_ok stays 0.
  - Owner's addr_ok = mem_addr_ok & mem_req.
  - On handshake (mem_req & mem_addr_ok) go to RESP.
  - If the owner drops req before the handshake, return to IDLE; nothing is issued.
- RESP:
  - mem_req=0.
  - On mem_data_ok: forward mem_rdata to the owner's rdata and pulse the owner's data_ok for that cycle, then go to IDLE.
  - rdata outputs are 0 whenever their data_ok is 0.
- Latency: request seen in IDLE at cycle N; mem_req rises at N+1; earliest owner data_ok is at N+2 (addr_ok at N+1, data_ok at N+2). There is a one-cycle IDLE bubble between back-to-back transactions.
- Cancel:
  - cancel_pend<=1 when inst_cancel & owner==inst & (state==RESP | (state==ADDR & handshake)).
  - inst_data_ok is suppressed when cancel_pend | inst_cancel at mem_data_ok. The response is still consumed and the FSM still returns to IDLE.
  - cancel_pend clears on mem_data_ok.
  - inst_cancel in ADDR without a handshake, or in IDLE, has no effect: the IF requester withdraws its own req.
  - inst_cancel while data is owner is ignored.
- Simultaneous events:
  - Requests from both masters in IDLE: data wins if DATA_PRIO=1. With DATA_PRIO=0, the master other than last_grant wins.
  - mem_data_ok outside RESP is ignored.
  - mem_addr_ok while mem_req=0 is ignored.
- No combinational path from mem_data_ok to mem_req.

Test Plan:
- Fetch alone: inst_req=1, inst_addr=0x1C000000, memory addr_ok at first mem_req and data_ok next cycle with rdata=0x02800C0C -> mem_req at cycle 1, inst_addr_ok at 1, inst_data_ok=1 with inst_rdata=0x02800C0C at 2; data_* outputs stay 0.
- Contention with DATA_PRIO=1: inst_req and data_req (wr=1, addr=0x1C008000, wstrb=0xF, wdata=0xDEADBEEF) in the same cycle -> data transaction issued first with mem_wr=1 and mem_wdata=0xDEADBEEF, inst_addr_ok=0 throughout; after data_data_ok, IDLE bubble, then the fetch is issued.
- Round-robin with DATA_PRIO=0: both requesters asserted continuously for 4 transactions -> grant order data, inst, data, inst following last_grant=0 after reset.
- Cancel: fetch accepted at 0x1C000010, inst_cancel pulsed during RESP, memory returns data_ok 3 cycles later -> inst_data_ok never asserts, FSM back in IDLE, next fetch served normally.
- Memory stall: mem_addr_ok held 0 for 5 cycles with data owner -> mem_req and mem_addr stable for all 5 cycles, data_addr_ok=0, then handshake on cycle 6.
- Reset mid-RESP: resetn low while awaiting mem_data_ok -> all outputs 0 immediately; after release, a late mem_data_ok produces no data_ok on either master.
